// File: rtl/remote_send.sv
// remote_send: NEC infrared frame transmitter.
// Sends a full frame (lead, 32 pulse-distance bits, stop) or a repeat frame.
// remote_env is the unmodulated mark/space envelope. remote_out gates that
// envelope with a carrier that restarts high at the start of every mark.
module remote_send #(
   parameter int unsigned UNIT_CYCLES  = 28125,
   parameter int unsigned CARRIER_HALF = 658
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       start,
   input  logic       rpt,
   input  logic [7:0] addr,
   input  logic [7:0] data,
   output logic       remote_out,
   output logic       remote_env,
   output logic       busy,
   output logic       done
);

   localparam int unsigned UW = (UNIT_CYCLES  > 1) ? $clog2(UNIT_CYCLES)  : 1;
   localparam int unsigned CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } state_t;

   state_t        state_q,    state_d;
   logic [UW-1:0] unit_cnt_q, unit_cnt_d;   // cycle within current unit
   logic [4:0]    unit_num_q, unit_num_d;   // unit within current state
   logic [4:0]    bit_cnt_q,  bit_cnt_d;    // data bit being sent
   logic [31:0]   shreg_q,    shreg_d;      // remaining bits, LSB next
   logic          rpt_q,      rpt_d;
   logic [CW-1:0] car_cnt_q,  car_cnt_d;
   logic          car_q,      car_d;
   logic          env_q,      env_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;

   logic [4:0]    dur_units;
   logic          unit_last;
   logic          state_end;
   logic          enter_mark;
   logic          mark_d;

   // Length of the current state in units, and end-of-state detection.
   always_comb begin
      dur_units = 5'd1;
      case (state_q)
         LEAD_MARK:  dur_units = 5'd16;
         LEAD_SPACE: dur_units = rpt_q ? 5'd4 : 5'd8;
         BIT_SPACE:  dur_units = shreg_q[0] ? 5'd3 : 5'd1;
         default:    dur_units = 5'd1;
      endcase
      unit_last = (unit_cnt_q == UNIT_LAST);
      state_end = unit_last && (unit_num_q == (dur_units - 5'd1));
   end

   // Next-state logic: sequencing, counters, carrier and registered outputs.
   always_comb begin
      state_d    = state_q;
      unit_cnt_d = unit_cnt_q;
      unit_num_d = unit_num_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      rpt_d      = rpt_q;
      enter_mark = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LEAD_MARK;
               shreg_d    = {~data, data, ~addr, addr};
               rpt_d      = rpt;
               bit_cnt_d  = '0;
               unit_cnt_d = '0;
               unit_num_d = '0;
               enter_mark = 1'b1;
            end
         end
         default: begin
            if (state_end) begin
               unit_cnt_d = '0;
               unit_num_d = '0;
               case (state_q)
                  LEAD_MARK: state_d = LEAD_SPACE;
                  LEAD_SPACE: begin
                     state_d    = rpt_q ? STOP_MARK : BIT_MARK;
                     enter_mark = 1'b1;
                  end
                  BIT_MARK: state_d = BIT_SPACE;
                  BIT_SPACE: begin
                     shreg_d    = shreg_q >> 1;
                     bit_cnt_d  = bit_cnt_q + 5'd1;
                     state_d    = (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                     enter_mark = 1'b1;
                  end
                  default: state_d = IDLE;
               endcase
            end else if (unit_last) begin
               unit_cnt_d = '0;
               unit_num_d = unit_num_q + 5'd1;
            end else begin
               unit_cnt_d = unit_cnt_q + 1'b1;
            end
         end
      endcase

      mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) ||
               (state_d == STOP_MARK);
      env_d  = mark_d;
      busy_d = (state_d != IDLE);
      // STOP_MARK is one unit long, so its last cycle is the last unit cycle.
      done_d = (state_d == STOP_MARK) && (unit_cnt_d == UNIT_LAST);

      if (enter_mark) begin
         car_d     = 1'b1;
         car_cnt_d = '0;
      end else if (!mark_d) begin
         car_d     = 1'b0;
         car_cnt_d = '0;
      end else if (car_cnt_q == CAR_LAST) begin
         car_d     = ~car_q;
         car_cnt_d = '0;
      end else begin
         car_d     = car_q;
         car_cnt_d = car_cnt_q + 1'b1;
      end
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         unit_cnt_q <= '0;
         unit_num_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         rpt_q      <= 1'b0;
         car_cnt_q  <= '0;
         car_q      <= 1'b0;
         env_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         unit_cnt_q <= unit_cnt_d;
         unit_num_q <= unit_num_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         rpt_q      <= rpt_d;
         car_cnt_q  <= car_cnt_d;
         car_q      <= car_d;
         env_q      <= env_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign remote_env = env_q;
   assign remote_out = env_q & car_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_remote_send.sv
// tb_remote_send: randomized scoreboard bench for remote_send.
module tb_remote_send;

   localparam int U = 10;
   localparam int C = 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       start;
   logic       rpt;
   logic [7:0] addr;
   logic [7:0] data;
   logic       remote_out;
   logic       remote_env;
   logic       busy;
   logic       done;

   remote_send #(.UNIT_CYCLES(U), .CARRIER_HALF(C)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .rpt        (rpt),
      .addr       (addr),
      .data       (data),
      .remote_out (remote_out),
      .remote_env (remote_env),
      .busy       (busy),
      .done       (done)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic       r;
      logic [7:0] a;
      logic [7:0] d;
   } frame_t;

   frame_t exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_frames = 0;

   // monitor state
   bit     cap[$];
   bit     exp_env[$];
   int     done_pos[$];
   int     car_err    = 0;
   int     idle_err   = 0;
   int     done_total = 0;
   int     mark_pos   = 0;
   bit     in_frame   = 0;
   logic   exp_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_seg(input bit lvl, input int units);
      for (int i = 0; i < units * U; i++) exp_env.push_back(lvl);
   endtask

   // Compare one captured busy window against the reference frame.
   task automatic check_frame();
      frame_t      f;
      logic [31:0] expw;
      logic [31:0] word;
      int          runs[$];
      int          errs;
      int          m;
      int          nb;
      if (exp_q.size() == 0) begin
         chk("unexpected_frame_len", cap.size(), 0);
      end else begin
         f = exp_q.pop_front();
         expw = {~f.d, f.d, ~f.a, f.a};
         exp_env.delete();
         add_seg(1, 16);
         add_seg(0, f.r ? 4 : 8);
         if (!f.r)
            for (int i = 0; i < 32; i++) begin
               add_seg(1, 1);
               add_seg(0, expw[i] ? 3 : 1);
            end
         add_seg(1, 1);
         chk("busy_cycles", cap.size(), exp_env.size());
         m = (cap.size() < exp_env.size()) ? cap.size() : exp_env.size();
         errs = 0;
         for (int i = 0; i < m; i++) if (cap[i] != exp_env[i]) errs++;
         chk("env_mismatch_cycles", errs, 0);
         if (!f.r) begin
            for (int i = 0; i < cap.size(); i++) begin
               if (i == 0 || cap[i] != cap[i-1]) runs.push_back(1);
               else runs[runs.size()-1]++;
            end
            word = '0;
            nb = 0;
            for (int r = 2; r + 1 < runs.size() && nb < 32; r += 2) begin
               word[nb] = (runs[r+1] > 2 * U);
               nb++;
            end
            chk("decoded_word", word, expw);
         end
         chk("done_pulses", done_pos.size(), 1);
         if (done_pos.size() > 0) chk("done_position", done_pos[0], cap.size() - 1);
         chk("carrier_errors", car_err, 0);
      end
      cap.delete();
      done_pos.delete();
      car_err = 0;
   endtask

   // Monitor: capture each busy window and check carrier cycle by cycle.
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         cap.delete();
         done_pos.delete();
         car_err  = 0;
         mark_pos = 0;
         in_frame = 0;
      end else if (busy === 1'b1) begin
         in_frame = 1;
         if (done === 1'b1) begin
            done_pos.push_back(cap.size());
            done_total++;
         end
         cap.push_back(remote_env);
         exp_out  = (remote_env === 1'b1) ? (((mark_pos / C) % 2) == 0) : 1'b0;
         mark_pos = (remote_env === 1'b1) ? mark_pos + 1 : 0;
         if (remote_out !== exp_out) car_err++;
      end else begin
         if (remote_out !== 1'b0 || done !== 1'b0) idle_err++;
         mark_pos = 0;
         if (in_frame) begin
            check_frame();
            in_frame = 0;
         end
      end
   end

   task automatic send(input bit r, input logic [7:0] a, input logic [7:0] d, input bit accept);
      frame_t f;
      @(negedge sys_clk);
      start = 1'b1;
      rpt   = r;
      addr  = a;
      data  = d;
      if (accept) begin
         f.r = r; f.a = a; f.d = d;
         exp_q.push_back(f);
         n_frames++;
      end
      @(negedge sys_clk);
      start = 1'b0;
      rpt   = 1'($urandom);
      addr  = 8'($urandom);
      data  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("frame_ends_in_time", busy, 0);
   endtask

   initial begin
      int n;
      sys_rst_n = 1'b0;
      start = 1'b0; rpt = 1'b0; addr = '0; data = '0;
      repeat (3) @(negedge sys_clk);
      chk("reset_busy", busy, 0);
      chk("reset_env", remote_env, 0);
      chk("reset_out", remote_out, 0);
      chk("reset_done", done, 0);
      #2 sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);

      // directed full frame and repeat frame
      send(1'b0, 8'h00, 8'h45, 1'b1);
      chk("busy_after_start", busy, 1);
      chk("env_after_start", remote_env, 1);
      wait_idle();
      repeat (4) @(negedge sys_clk);
      send(1'b1, 8'h3C, 8'hA5, 1'b1);
      wait_idle();

      // random frames
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(1, 6)) @(negedge sys_clk);
         send($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), 1'b1);
         wait_idle();
      end

      // start while busy must be ignored
      send(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      repeat (498) @(negedge sys_clk);
      send(1'b0, 8'hFF, 8'($urandom), 1'b0);
      wait_idle();
      repeat (20) @(negedge sys_clk);
      chk("no_queued_frame", busy, 0);

      // reset in the middle of a frame
      send(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      repeat (299) @(negedge sys_clk);
      chk("pre_reset_busy", busy, 1);
      #2 sys_rst_n = 1'b0;
      void'(exp_q.pop_back());
      n_frames--;
      #1;
      chk("abort_out", remote_out, 0);
      chk("abort_env", remote_env, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (3) @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      chk("idle_after_reset", busy, 0);
      send(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      wait_idle();

      // back-to-back frames
      repeat (3) @(negedge sys_clk);
      send(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("b2b_done_seen", done, 1);
      send($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 1'b1);
      chk("b2b_restart_busy", busy, 1);
      wait_idle();

      repeat (10) @(negedge sys_clk);
      chk("pending_expected", exp_q.size(), 0);
      chk("done_total", done_total, n_frames);
      chk("idle_output_errors", idle_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/remote_send.md
REMOTE_SEND -- requirements
Module: remote_send

Interface
Parameters:
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 28125, giving sys_clk cycles per NEC time unit (562.5 us at 50 MHz).
REQ-002 The block SHALL have parameter CARRIER_HALF, default 658, giving sys_clk cycles per carrier half-period (about 38 kHz at 50 MHz).

Ports:
REQ-003 The block SHALL have port sys_clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to send a frame.
REQ-006 The block SHALL have port rpt, input, 1 bit: sampled with start; 1 selects a repeat frame, 0 a full frame.
REQ-007 The block SHALL have port addr, input, 8 bits: NEC address byte.
REQ-008 The block SHALL have port data, input, 8 bits: NEC command byte.
REQ-009 The block SHALL have port remote_out, output, 1 bit: modulated IR LED drive, 1 = LED on.
REQ-010 The block SHALL have port remote_env, output, 1 bit: unmodulated envelope, 1 = mark.
REQ-011 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-013 start SHALL be accepted only on a cycle with busy=0; start with busy=1 SHALL be ignored and never queued.
REQ-014 On acceptance, addr, data and rpt SHALL be latched; later input changes SHALL not affect the frame.
REQ-015 busy, remote_env and the first mark SHALL assert on the cycle after acceptance (latency 1).
REQ-016 The FSM SHALL have states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
- All durations are whole multiples of UNIT_CYCLES.
REQ-017 Full frame sequence:
- LEAD_MARK 16 units.
- LEAD_SPACE 8 units.
- 32 times BIT_MARK 1 unit, then BIT_SPACE of 1 unit (bit 0) or 3 units (bit 1).
- STOP_MARK 1 unit.
- Then IDLE.
REQ-018 Full-frame bit order SHALL be addr, ~addr, data, ~data, each byte LSB first.
REQ-019 Repeat frame sequence: LEAD_MARK 16 units, LEAD_SPACE 4 units, STOP_MARK 1 unit, then IDLE; no data bits.
REQ-020 A full frame SHALL last exactly 121 units and a repeat frame exactly 21 units, both measured as busy-high cycles.
REQ-021 remote_env SHALL be 1 in mark states and 0 otherwise.
REQ-022 remote_out SHALL be remote_env AND carrier.
- The carrier toggles every CARRIER_HALF cycles.
- The carrier restarts high on the first cycle of every mark.
REQ-023 On the last cycle of STOP_MARK, done SHALL pulse high for exactly one cycle, and busy SHALL fall on the next cycle.
REQ-024 Start SHALL be accepted on the first cycle busy=0 after done, allowing back-to-back frames with zero gap; the caller enforces the inter-frame gap.
REQ-025 Unit and carrier counters SHALL be wide enough for the parameter values and SHALL not wrap within a state.

Reset
REQ-026 While sys_rst_n=0, the FSM SHALL be in IDLE, all counters SHALL be 0, and remote_out, remote_env, busy and done SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL force remote_out=0 immediately (asynchronously), and the frame SHALL be discarded.
REQ-028 After release, the block SHALL require a new start.

Verification
(UNIT_CYCLES=10, CARRIER_HALF=2)
REQ-029 Full frame: addr=0x00, data=0x45, rpt=0, start pulse.
- busy high 1210 cycles.
- remote_env decodes bytes 00 FF 45 BA LSB first.
- done pulses once.
REQ-030 Repeat frame: rpt=1, start pulse.
- remote_env is 160 high, 40 low, 10 high.
- busy high 210 cycles.
REQ-031 Carrier check: during any mark, remote_out SHALL read 1,1,0,0 repeating from the mark's first cycle; during any space, remote_out SHALL be constantly 0.
REQ-032 start pulsed at cycle 500 of a frame with addr=0xFF: the frame in progress SHALL be unchanged, with no second frame and one done.
REQ-033 sys_rst_n low at cycle 300 of a full frame:
- remote_out, remote_env, busy SHALL be 0 at once.
- done SHALL not pulse.
- A new start after release SHALL send a complete correct frame.
REQ-034 start on the cycle after done: the second frame's LEAD_MARK SHALL begin with no idle gap, and both frames SHALL be correct.
